// File: rtl/mesi_pkg.sv
// Shared MESI bus definitions: bus ops, responder FSM states, cache line states.
package mesi_pkg;

   typedef enum logic [1:0] {
      OP_READ_MISS  = 2'd0,
      OP_WRITE_MISS = 2'd1,
      OP_INVALIDATE = 2'd2,
      OP_WRITEBACK  = 2'd3
   } bus_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SNOOP,
      ST_WB,
      ST_READ,
      ST_RESP
   } mem_state_e;

   typedef enum logic [1:0] {
      LINE_I = 2'd0,
      LINE_S = 2'd1,
      LINE_M = 2'd2,
      LINE_E = 2'd3
   } line_state_e;

endpackage

// File: rtl/mesi_mem_array.sv
// Backing store: synchronous write, registered read address, no reset on contents.
module mesi_mem_array #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];
   logic [ADDR_W-1:0] r_raddr;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      r_raddr <= i_raddr;
   end

   assign o_rdata = r_mem[r_raddr];

endmodule

// File: rtl/mesi_bus_memory.sv
// Memory responder on the snooping MESI bus: snoop window, write-back merge, line return.
// MESI_MEM_FWD_EN: forward snooped write-back data straight from WB instead of re-reading memory.
module mesi_bus_memory
   import mesi_pkg::*;
#(
   parameter int ADDR_W       = 5,
   parameter int DATA_W       = 8,
   parameter int SNOOP_CYCLES = 1,
   parameter int MEM_LATENCY  = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_src,
   input  logic [DATA_W-1:0] req_data,
   input  logic              snoop_abort,
   input  logic [DATA_W-1:0] snoop_wb_data,
   input  logic              snoop_share,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_shared,
   output logic [1:0]        resp_dst,
   output logic              busy
);

   localparam int SNP_W = (SNOOP_CYCLES > 1) ? $clog2(SNOOP_CYCLES) : 1;
   localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [SNP_W-1:0] SNP_LAST = SNP_W'(SNOOP_CYCLES - 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);

   mem_state_e        r_state, w_next;
   bus_op_e           r_op;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_src;
   logic [DATA_W-1:0] r_wb_data;
   logic              r_abort, r_share;
   logic [SNP_W-1:0]  r_snoop_cnt;
   logic [LAT_W-1:0]  r_lat_cnt;
   logic [DATA_W-1:0] r_resp_data;
   logic              r_resp_shared;
   logic [1:0]        r_resp_dst;

   logic              w_accept, w_load_resp, w_wb_cycle, w_resp_shared, w_mem_we;
   logic [DATA_W-1:0] w_resp_data, w_rd_data;

   assign w_accept      = (r_state == ST_IDLE) && req_valid;
   assign w_resp_shared = (r_op == OP_READ_MISS) && (r_share || r_abort);

   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_load_resp = 1'b0;
      w_wb_cycle  = 1'b0;
      w_resp_data = '0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid)
               w_next = (bus_op_e'(req_op) == OP_WRITEBACK) ? ST_WB : ST_SNOOP;
         end
         ST_SNOOP: begin
            if (r_snoop_cnt == SNP_LAST) begin
               if (r_op == OP_INVALIDATE) begin
                  w_next      = ST_RESP;
                  w_load_resp = 1'b1;
               end else if (r_abort || snoop_abort) begin
                  w_next = ST_WB;
               end else begin
                  w_next = ST_READ;
               end
            end
         end
         ST_WB: begin
            w_wb_cycle = 1'b1;
            if (r_op == OP_WRITEBACK) begin
               w_next      = ST_RESP;
               w_load_resp = 1'b1;
            end else begin
`ifdef MESI_MEM_FWD_EN
               w_next      = ST_RESP;
               w_load_resp = 1'b1;
               w_resp_data = r_wb_data;
`else
               w_next = ST_READ;
`endif
            end
         end
         ST_READ: begin
            if (r_lat_cnt == LAT_LAST) begin
               w_next      = ST_RESP;
               w_load_resp = 1'b1;
               w_resp_data = w_rd_data;
            end
         end
         ST_RESP: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Accumulators include the current cycle's snoop inputs; first abort owns the data.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_op          <= OP_READ_MISS;
         r_addr        <= '0;
         r_src         <= '0;
         r_wb_data     <= '0;
         r_abort       <= 1'b0;
         r_share       <= 1'b0;
         r_snoop_cnt   <= '0;
         r_lat_cnt     <= '0;
         r_resp_data   <= '0;
         r_resp_shared <= 1'b0;
         r_resp_dst    <= '0;
      end else begin
         if (w_accept) begin
            r_op        <= bus_op_e'(req_op);
            r_addr      <= req_addr;
            r_src       <= req_src;
            r_wb_data   <= req_data;
            r_abort     <= 1'b0;
            r_share     <= 1'b0;
            r_snoop_cnt <= '0;
         end
         if (r_state == ST_SNOOP) begin
            r_snoop_cnt <= r_snoop_cnt + SNP_W'(1);
            r_abort     <= r_abort | snoop_abort;
            r_share     <= r_share | snoop_share;
            if (snoop_abort && !r_abort) r_wb_data <= snoop_wb_data;
            r_lat_cnt   <= '0;
         end
         if (r_state == ST_WB)   r_lat_cnt <= '0;
         if (r_state == ST_READ) r_lat_cnt <= r_lat_cnt + LAT_W'(1);
         if (w_load_resp) begin
            r_resp_data   <= w_resp_data;
            r_resp_shared <= w_resp_shared;
            r_resp_dst    <= r_src;
         end
      end
   end

   assign w_mem_we = w_wb_cycle && !reset;

   mesi_mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .i_clk   (clock),
      .i_we    (w_mem_we),
      .i_waddr (r_addr),
      .i_wdata (r_wb_data),
      .i_raddr (r_addr),
      .o_rdata (w_rd_data)
   );

   assign req_ready   = (r_state == ST_IDLE) && !reset;
   assign busy        = (r_state != ST_IDLE);
   assign resp_valid  = (r_state == ST_RESP);
   assign resp_data   = r_resp_data;
   assign resp_shared = r_resp_shared;
   assign resp_dst    = r_resp_dst;

endmodule
